// File: rtl/sweep_pkg.sv
// Shared types and the signature update used by the pattern sweep block.
package sweep_pkg;
  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

  typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} sweep_state_e;

  // One MISR step: shift, fold in the polynomial on MSB carry-out, xor the record.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] din);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ din;
  endfunction
endpackage

// File: rtl/pattern_sweep_capture_if.sv
// Record stream between the sweep block and its consumer (valid/ready).
interface pattern_sweep_capture_if #(parameter int DW = 3);
  logic          rec_valid;
  logic          rec_ready;
  logic [DW-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/sweep_fifo.sv
// Show-ahead record buffer; push and pop may coincide, even when full.
module sweep_fifo #(
  parameter int DW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_valid,
  output logic [DW-1:0] o_dout
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic [AW-1:0]            r_wp, r_rp;
  logic [AW:0]              r_cnt;
  logic                     w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign o_dout  = r_mem[r_rp];
  assign w_pop   = i_pop & o_valid;

  always_ff @(posedge gclk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/pattern_sweep_capture.sv
// Walks stim through every value, samples resp after SETTLE cycles and buffers {stim, resp}.
// Optional response MISR on `signature` when SWEEP_MISR_EN is defined.
module pattern_sweep_capture
  import sweep_pkg::*;
#(
  parameter int IN_W       = 2,
  parameter int OUT_W      = 1,
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CK,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IN_W-1:0]    stim,
  input  logic [OUT_W-1:0]   resp,
  pattern_sweep_capture_if.master rec,
  output logic [SIG_W-1:0]   signature
);
  localparam int REC_W = IN_W + OUT_W;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [IN_W-1:0]  STIM_LAST = '1;

  sweep_state_e     r_state;
  logic             r_busy, r_done;
  logic [IN_W-1:0]  r_stim;
  logic [CNT_W-1:0] r_cnt;

  logic             w_full, w_valid, w_pop, w_can_push, w_sample, w_push, w_start_acc;
  logic [REC_W-1:0] w_rec, w_dout;

  assign busy = r_busy;
  assign done = r_done;
  assign stim = r_stim;

  assign w_rec       = {r_stim, resp};
  assign w_pop       = w_valid & rec.rec_ready;
  assign w_can_push  = ~w_full | w_pop;
  assign w_sample    = ((r_state == RUN) && (r_cnt == CNT_LAST)) || (r_state == STALL);
  assign w_push      = w_sample & w_can_push;
  assign w_start_acc = start & ((r_state == IDLE) || (r_state == DONE));

  sweep_fifo #(.DW(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .gclk    (CK),
    .grst_n  (reset),
    .i_push  (w_push),
    .i_din   (w_rec),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_valid (w_valid),
    .o_dout  (w_dout)
  );

  assign rec.rec_valid = w_valid;
  assign rec.rec_data  = w_dout;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stim  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_acc) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_stim  <= '0;
            r_cnt   <= '0;
          end
        end
        RUN, STALL: begin
          // A stalled vector keeps its stim until the buffer frees a slot.
          if (w_push) begin
            r_cnt <= '0;
            if (r_stim == STIM_LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_stim  <= r_stim + IN_W'(1);
            end
          end else if (r_state == RUN) begin
            if (w_sample) r_state <= STALL;
            else          r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SWEEP_MISR_EN
  logic [SIG_W-1:0] r_sig;

  // Records wider than SIG_W fold in their low SIG_W bits only.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset)           r_sig <= '1;
    else if (w_start_acc) r_sig <= '1;
    else if (w_push)      r_sig <= misr_next(r_sig, SIG_W'(w_rec));
  end

  assign signature = r_sig;
`else
  assign signature = '0;
`endif
endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Scoreboard bench: three sweep instances (basic, stall/backpressure, long settle).
module tb_pattern_sweep_capture;
`ifdef SWEEP_MISR_EN
  localparam logic [15:0] SIG_RST = 16'hFFFF;
  localparam logic [15:0] SIG_AND = 16'h0E18;
  localparam logic [15:0] SIG_ZRO = 16'h0E19;
`else
  localparam logic [15:0] SIG_RST = 16'h0000;
  localparam logic [15:0] SIG_AND = 16'h0000;
  localparam logic [15:0] SIG_ZRO = 16'h0000;
`endif

  logic CK = 1'b0;
  logic reset;
  logic startA, startB, startC;
  logic busyA, busyB, busyC, doneA, doneB, doneC;
  logic [1:0] stimA, stimC;
  logic [2:0] stimB;
  logic respA, respB, respC, respA_zero;
  logic [15:0] sigA, sigB, sigC;
  int errors = 0;
  int checks = 0;
  logic [2:0] qA[$];
  logic [3:0] qB[$];
  logic [2:0] qC[$];

  always #5 CK = ~CK;

  pattern_sweep_capture_if #(.DW(3)) recA ();
  pattern_sweep_capture_if #(.DW(4)) recB ();
  pattern_sweep_capture_if #(.DW(3)) recC ();

  assign respA = respA_zero ? 1'b0 : (stimA[1] & stimA[0]);
  assign respB = ^stimB;
  assign respC = stimC[0];

  pattern_sweep_capture #(.IN_W(2), .OUT_W(1), .SETTLE(1), .FIFO_DEPTH(4)) dutA (
    .CK(CK), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
    .stim(stimA), .resp(respA), .rec(recA.master), .signature(sigA));
  pattern_sweep_capture #(.IN_W(3), .OUT_W(1), .SETTLE(1), .FIFO_DEPTH(4)) dutB (
    .CK(CK), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
    .stim(stimB), .resp(respB), .rec(recB.master), .signature(sigB));
  pattern_sweep_capture #(.IN_W(2), .OUT_W(1), .SETTLE(3), .FIFO_DEPTH(4)) dutC (
    .CK(CK), .reset(reset), .start(startC), .busy(busyC), .done(doneC),
    .stim(stimC), .resp(respC), .rec(recC.master), .signature(sigC));

  task automatic test_reset();
    reset = 1'b0; startA = 0; startB = 0; startC = 0; respA_zero = 0;
    recA.rec_ready = 0; recB.rec_ready = 0; recC.rec_ready = 0;
    #12;
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busyA); end
    checks++; if (doneA !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", doneA); end
    checks++; if (stimB !== 3'd0) begin errors++; $display("FAIL rst_stim: got %0d want 0", stimB); end
    checks++; if (recA.rec_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", recA.rec_valid); end
    checks++; if (sigA !== SIG_RST) begin errors++; $display("FAIL rst_sig: got %h want %h", sigA, SIG_RST); end
    @(posedge CK); #1 reset = 1'b1;
    @(posedge CK); #1;
  endtask

  // Sweep A, resp from a mode bit; checks stim order, done latency, records, signature.
  task automatic test_sweep_a(input logic zero, input logic [15:0] sig_exp, input string nm);
    int first_done = -1;
    int got = 0;
    logic [2:0] d;
    respA_zero = zero;
    recA.rec_ready = 1;
    for (int s = 0; s < 4; s++) begin
      d = {2'(s), (zero ? 1'b0 : (s == 3))};
      qA.push_back(d);
    end
    startA = 1; @(posedge CK); #1 startA = 0;
    @(negedge CK);
    checks++; if (sigA !== SIG_RST) begin errors++; $display("FAIL %s_sig_init: got %h want %h", nm, sigA, SIG_RST); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 4) begin
        checks++; if (stimA !== 2'(cyc)) begin errors++; $display("FAIL %s_stim%0d: got %0d want %0d", nm, cyc, stimA, cyc); end
      end
      if (doneA === 1'b1 && first_done < 0) first_done = cyc;
      if (recA.rec_valid && recA.rec_ready) begin
        checks++;
        if (qA.size() == 0) begin errors++; $display("FAIL %s_extra: got %b want none", nm, recA.rec_data); end
        else begin
          d = qA.pop_front(); got++;
          if (recA.rec_data !== d) begin errors++; $display("FAIL %s_rec: got %b want %b", nm, recA.rec_data, d); end
        end
      end
      if (first_done >= 0 && qA.size() == 0 && !recA.rec_valid) break;
      @(negedge CK);
    end
    checks++; if (first_done !== 4) begin errors++; $display("FAIL %s_done_lat: got %0d want 4", nm, first_done); end
    checks++; if (got !== 4) begin errors++; $display("FAIL %s_count: got %0d want 4", nm, got); end
    checks++; if (sigA !== sig_exp) begin errors++; $display("FAIL %s_sig: got %h want %h", nm, sigA, sig_exp); end
    qA.delete();
  endtask

  task automatic test_stall();
    int got = 0;
    logic [3:0] d;
    recB.rec_ready = 0;
    for (int s = 0; s < 8; s++) begin d = {3'(s), ^(3'(s))}; qB.push_back(d); end
    startB = 1; @(posedge CK); #1 startB = 0;
    repeat (10) @(negedge CK);
    checks++; if (stimB !== 3'b100) begin errors++; $display("FAIL stall_stim: got %b want 100", stimB); end
    checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busyB); end
    checks++; if (recB.rec_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", recB.rec_valid); end
    recB.rec_ready = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (recB.rec_valid && recB.rec_ready) begin
        checks++;
        if (qB.size() == 0) begin errors++; $display("FAIL stall_extra: got %b want none", recB.rec_data); end
        else begin
          d = qB.pop_front(); got++;
          if (recB.rec_data !== d) begin errors++; $display("FAIL stall_rec: got %b want %b", recB.rec_data, d); end
        end
      end
      if (doneB && qB.size() == 0 && !recB.rec_valid) break;
      @(negedge CK);
    end
    checks++; if (got !== 8) begin errors++; $display("FAIL stall_count: got %0d want 8", got); end
    checks++; if (doneB !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", doneB); end
    qB.delete();
  endtask

  // Buffer fills by edge 4; ready rises before edge 5 so push and pop coincide.
  task automatic test_full_no_stall();
    int got = 0;
    logic [3:0] d;
    recB.rec_ready = 0;
    for (int s = 0; s < 8; s++) begin d = {3'(s), ^(3'(s))}; qB.push_back(d); end
    startB = 1; @(posedge CK); #1 startB = 0;
    @(negedge CK);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 4) begin
        recB.rec_ready = 1;
        checks++; if (stimB !== 3'd4) begin errors++; $display("FAIL full_stim4: got %0d want 4", stimB); end
      end
      if (cyc == 5) begin
        checks++; if (stimB !== 3'd5) begin errors++; $display("FAIL full_nostall: got %0d want 5", stimB); end
      end
      if (recB.rec_valid && recB.rec_ready) begin
        checks++;
        if (qB.size() == 0) begin errors++; $display("FAIL full_extra: got %b want none", recB.rec_data); end
        else begin
          d = qB.pop_front(); got++;
          if (recB.rec_data !== d) begin errors++; $display("FAIL full_rec: got %b want %b", recB.rec_data, d); end
        end
      end
      if (cyc > 5 && doneB && qB.size() == 0 && !recB.rec_valid) break;
      @(negedge CK);
    end
    checks++; if (got !== 8) begin errors++; $display("FAIL full_count: got %0d want 8", got); end
    qB.delete();
  endtask

  task automatic test_settle();
    int first_done = -1;
    int got = 0;
    logic [2:0] d;
    recC.rec_ready = 1;
    for (int s = 0; s < 4; s++) begin d = {2'(s), 1'(s & 1)}; qC.push_back(d); end
    startC = 1; @(posedge CK); #1 startC = 0;
    @(negedge CK);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc < 12) begin
        checks++; if (stimC !== 2'(cyc / 3)) begin errors++; $display("FAIL settle_stim%0d: got %0d want %0d", cyc, stimC, cyc / 3); end
      end
      if (doneC === 1'b1 && first_done < 0) first_done = cyc;
      if (recC.rec_valid && recC.rec_ready) begin
        checks++;
        if (qC.size() == 0) begin errors++; $display("FAIL settle_extra: got %b want none", recC.rec_data); end
        else begin
          d = qC.pop_front(); got++;
          if (recC.rec_data !== d) begin errors++; $display("FAIL settle_rec: got %b want %b", recC.rec_data, d); end
        end
      end
      if (first_done >= 0 && qC.size() == 0 && !recC.rec_valid) break;
      @(negedge CK);
    end
    checks++; if (first_done !== 12) begin errors++; $display("FAIL settle_done_lat: got %0d want 12", first_done); end
    checks++; if (got !== 4) begin errors++; $display("FAIL settle_count: got %0d want 4", got); end
    qC.delete();
  endtask

  task automatic test_restart_and_reset();
    respA_zero = 0;
    recA.rec_ready = 0;
    startA = 1; @(posedge CK); #1 startA = 0;
    @(negedge CK);
    startA = 1;
    @(negedge CK);
    startA = 0;
    @(negedge CK);
    checks++; if (stimA !== 2'b10) begin errors++; $display("FAIL norestart_stim: got %b want 10", stimA); end
    checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL norestart_busy: got %b want 1", busyA); end
    reset = 1'b0;
    #1;
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busyA); end
    checks++; if (stimA !== 2'b00) begin errors++; $display("FAIL midrst_stim: got %b want 00", stimA); end
    checks++; if (recA.rec_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", recA.rec_valid); end
    @(posedge CK); #1 reset = 1'b1;
    repeat (3) @(negedge CK);
    checks++; if (busyA !== 1'b0 || stimA !== 2'b00) begin errors++; $display("FAIL postrst_idle: got busy=%b stim=%b want 0/00", busyA, stimA); end
  endtask

  initial begin
    test_reset();
    test_sweep_a(1'b0, SIG_AND, "basic");
    test_sweep_a(1'b1, SIG_ZRO, "misr");
    test_stall();
    test_full_no_stall();
    test_settle();
    test_restart_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pattern_sweep_capture.md
PATTERN_SWEEP_CAPTURE -- requirements
Module: pattern_sweep_capture

Interface
REQ-001 Parameter IN_W, default 2: stimulus width in bits; valid range 1..16.
REQ-002 Parameter OUT_W, default 1: response width in bits; valid range 1..16.
REQ-003 Parameter SETTLE, default 1: cycles each vector is held before sampling; minimum 1.
REQ-004 Parameter FIFO_DEPTH, default 4: record buffer entries; power of two, minimum 2.
REQ-005 CK  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a sweep.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high from sweep completion until the next accepted start.
REQ-010 stim  output  IN_W  stimulus vector driven to the device under test.
REQ-011 resp  input  OUT_W  device-under-test response.
REQ-012 rec_valid  output  1  a record is available on rec_data.
REQ-013 rec_ready  input  1  consumer accepts the record.
REQ-014 rec_data  output  IN_W+OUT_W  record {stim, resp}, with stim in the MSBs.
REQ-015 signature  output  SIG_W  response signature; SIG_W comes from the package.

Function
REQ-016 FSM states: IDLE, RUN, STALL, DONE.
REQ-017 start in IDLE or DONE: go to RUN, drive stim=0, clear settle counter, clear done, set busy.
REQ-018 start in RUN or STALL: ignored.
REQ-019 In RUN, each vector is held exactly SETTLE cycles; resp is sampled on the SETTLE-th rising edge after stim changes.
REQ-020 On the sample edge, {stim, resp} is pushed to the buffer; the next vector (stim+1) is driven on the same edge.
REQ-021 With no backpressure, a sweep takes exactly 2^IN_W*SETTLE cycles, and records appear in ascending stim order.
REQ-022 Buffer full at the sample edge with no simultaneous pop: enter STALL, hold stim, do not push.
REQ-023 In STALL: push on the first edge with space (not full, or pop on the same edge), then advance as in RUN.
REQ-024 Last vector (stim = all ones): after its push, enter DONE, clear busy, set done, hold stim at all ones.
REQ-025 Buffer semantics: show-ahead FIFO; rec_valid = not empty; pop occurs when rec_valid and rec_ready are both high.
REQ-026 Simultaneous push and pop: both succeed, including when the buffer is full.
REQ-027 The buffer is not cleared by start; records from a previous sweep remain readable.
REQ-028 No record is lost or duplicated under any rec_ready pattern.

Reset
REQ-029 reset low forces the following, asynchronously: state IDLE, busy=0, done=0, stim=0, buffer empty (rec_valid=0), settle counter 0, signature all ones.
REQ-030 Reset asserted mid-sweep: the sweep is abandoned; a new start is required after reset releases.

Configuration
REQ-031 Macro SWEEP_MISR_EN defined: signature is a SIG_W-bit MISR.
- Set to all ones on accepted start and on reset.
- On each push: sig <= (sig<<1) ^ (sig[MSB] ? SIG_POLY : 0) ^ zero-extended {stim, resp}.
REQ-032 Macro SWEEP_MISR_EN undefined: signature is tied to 0, and no MISR logic is present.

Structure
REQ-033 Package sweep_pkg holds:
- SIG_W = 16 and SIG_POLY = 16'h1021;
- the state enum type;
- the function that computes the MISR update.
REQ-034 The record buffer is the sub-module sweep_fifo, parametrised by data width and depth.

Verification
REQ-035 IN_W=2, OUT_W=1, SETTLE=1, resp = stim[1]&stim[0], rec_ready=1 -> records 000, 010, 100, 111 in order; done rises 4 cycles after start.
REQ-036 IN_W=3, FIFO_DEPTH=4, rec_ready=0 -> STALL with stim=3'b100 held. Raise rec_ready -> all 8 records arrive in order, none missing.
REQ-037 SETTLE=3, IN_W=2 -> each stim value is held exactly 3 cycles; done 12 cycles after start.
REQ-038 Reset pulled low with stim=2'b10 mid-sweep -> busy=0, stim=0, rec_valid=0 immediately. A start pulse during RUN -> no restart.
REQ-039 SWEEP_MISR_EN defined, IN_W=2, OUT_W=1, resp=0 -> signature = 16'h0E19 at done. Macro undefined -> signature = 0.
REQ-040 Full buffer with rec_ready=1 on the sample edge -> push and pop both occur; no STALL entered.
